// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: request/response memory port feeding a DEPTH-entry prefetch queue.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a FAULT state.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        busy,
    output logic        fetch_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [PW-1:0] PONE  = PW'(1);
    localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] live_q, live_d, disc_q, disc_d, cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          req_fire, push, pop, redirect_bad;
    logic [31:0]   redirect_tgt;

    always_comb begin
        redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
        redirect_bad = 1'b0;
`endif
    end

    // Credits: queue space covers every live request, and the response tracker never overflows.
    assign imem_req_valid = !rst && (state_q == ST_RUN)
                         && (({1'b0, cnt_q} + {1'b0, live_q}) < LIMIT)
                         && (({1'b0, live_q} + {1'b0, disc_q}) < LIMIT)
                         && !redirect;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = imem_resp_valid && (disc_q == '0) && !redirect;
    assign inst_valid     = (cnt_q != '0);
    assign pop            = inst_valid && inst_ready && !redirect;
    assign inst_out       = inst_valid ? data_mem[rd_ptr_q] : '0;
    assign inst_pc        = inst_valid ? pc_mem[rd_ptr_q] : '0;
    assign busy           = (live_q != '0) || (disc_q != '0);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault    = (state_q == ST_FAULT);
`else
    assign fetch_fault    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        disc_d     = disc_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect) begin
            // Everything still in flight becomes stale; a response this cycle retires one of them.
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            disc_d     = disc_q + live_q - (imem_resp_valid ? ONE : '0);
            live_d     = '0;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            state_d    = redirect_bad ? ST_FAULT : ST_RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                live_d     = live_q + ONE;
            end
            if (imem_resp_valid) begin
                if (disc_q != '0) begin
                    disc_d = disc_q - ONE;
                end else begin
                    live_d    = live_d - ONE;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + PONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PONE;
            cnt_d = cnt_q + (push ? ONE : '0) - (pop ? ONE : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            live_q     <= '0;
            disc_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            disc_q     <= disc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_resp_data;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: in-order memory model, expected-PC queue, decoupled monitor.
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        busy;
    logic        fetch_fault;

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
        .busy(busy), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    exp_t  exp_q[$];
    pend_t pend_q[$];

    int n_checks = 0, n_fail = 0;
    int n_out = 0, phase_outs = 0, first_cyc = 0, last_cyc = 0, n_req = 0, lat = 1, rel_cyc = 0;
    bit rand_rdy = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_stream(input logic [31:0] pc0, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = pc0 + 32'(4 * i);
            e.data = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // Memory model: in-order responses, lat cycles after acceptance, cleared by rst.
    initial begin : memory
        pend_t p;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pend_q.delete();
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
                imem_req_ready  = 1'b0;
            end else begin
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end else begin
                    imem_resp_valid = 1'b0;
                    imem_resp_data  = '0;
                end
                imem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                if (imem_req_valid && imem_req_ready) begin
                    p.addr = imem_req_addr;
                    p.due  = cyc + lat;
                    pend_q.push_back(p);
                    n_req++;
                end
            end
        end
    end

    // Monitor: every accepted output is checked against the head of the expected queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && inst_valid && inst_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h, required no output", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", inst_pc, e.pc);
                    chk("out_data", inst_out, e.data);
                end
                if (phase_outs == 0) first_cyc = cyc;
                last_cyc = cyc;
                phase_outs++;
                n_out++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_out", inst_out, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fetch_fault", fetch_fault, 0);
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        phase_outs = 0;
    endtask

    task automatic do_redirect(input logic [31:0] pc, input logic [31:0] exp_pc, input int n);
        redirect    = 1'b1;
        redirect_pc = pc;
        exp_q.delete();
        expect_stream(exp_pc, n);
        phase_outs = 0;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget, input string name);
        int tgt;
        tgt = n_out + n;
        for (int k = 0; k < budget && n_out < tgt; k++) @(negedge clk);
        chk(name, 32'(n_out >= tgt), 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int d;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

        // Streaming from reset, 1-cycle memory, consumer always ready
        lat = 1; rand_rdy = 1'b0; inst_ready = 1'b1;
        do_reset();
        expect_stream(32'h0, 64);
        wait_outs(16, 100, "t1_stream_timeout");
        chk("t1_first_valid_cycle", 32'(first_cyc - rel_cyc), 2);
        chk("t1_no_bubbles", 32'(last_cyc - first_cyc), 15);

        // Backpressure: exactly DEPTH requests, then refill after one pop
        inst_ready = 1'b0;
        do_reset();
        n_req = 0;
        expect_stream(32'h0, 64);
        repeat (12) @(negedge clk);
        #3;
        chk("t2_req_count", 32'(n_req), DEPTH);
        chk("t2_req_valid_stalled", imem_req_valid, 0);
        chk("t2_head_pc", inst_pc, 32'h0);
        chk("t2_head_data", inst_out, mem_word(32'h0));
        chk("t2_busy_idle", busy, 0);
        @(negedge clk);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        #3;
        chk("t2_refill_valid", imem_req_valid, 1);
        chk("t2_refill_addr", imem_req_addr, 32'h10);
        @(negedge clk);
        inst_ready = 1'b1;
        wait_outs(10, 100, "t2_resume_timeout");

        // Latency 3: redirect with two live requests outstanding
        lat = 3;
        do_reset();
        repeat (2) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h100;
        exp_q.delete(); expect_stream(32'h100, 64); phase_outs = 0;
        #3;
        chk("t3_no_req_on_redirect", imem_req_valid, 0);
        chk("t3_busy_live", busy, 1);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("t3_busy_discard", busy, 1);
        chk("t3_new_req_valid", imem_req_valid, 1);
        chk("t3_new_req_addr", imem_req_addr, 32'h100);
        wait_outs(12, 200, "t3_stream_timeout");
        inst_ready = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        chk("t3_busy_drained", busy, 0);
        chk("t3_full_no_req", imem_req_valid, 0);
        chk("t3_full_valid", inst_valid, 1);
        @(negedge clk);
        inst_ready = 1'b1;

        // Redirect in the same cycle as a response and a pop
        lat = 1;
        do_reset();
        expect_stream(32'h0, 64);
        wait_outs(6, 50, "t4_pre_timeout");
        d = cyc;
        redirect = 1'b1; redirect_pc = 32'h200;
        exp_q.delete(); expect_stream(32'h200, 64); phase_outs = 0;
        #3;
        chk("t4_resp_coincide", imem_resp_valid, 1);
        chk("t4_pop_coincide", inst_valid, 1);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("t4_flushed", inst_valid, 0);
        chk("t4_nothing_stale", busy, 0);
        wait_outs(10, 100, "t4_stream_timeout");
        chk("t4_first_out_cycle", 32'(first_cyc - d), 3);

        // Random memory acceptance and random consumer
        lat = 2; rand_rdy = 1'b1;
        @(negedge clk);
        do_redirect(32'h400, 32'h400, 400);
        d = n_out + 40;
        for (int k = 0; k < 3000 && n_out < d; k++) begin
            inst_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("t5_random_timeout", 32'(n_out >= d), 1);
        rand_rdy = 1'b0; inst_ready = 1'b1; lat = 1;
        @(negedge clk);

        // Misaligned redirect
`ifdef FETCH_MISALIGN_TRAP_EN
        do_redirect(32'h102, 32'h0, 0);
        #3;
        chk("t6_fault_set", fetch_fault, 1);
        chk("t6_fault_no_req", imem_req_valid, 0);
        repeat (5) @(negedge clk);
        #3;
        chk("t6_fault_held", fetch_fault, 1);
        chk("t6_fault_still_no_req", imem_req_valid, 0);
        chk("t6_fault_drained", busy, 0);
        chk("t6_fault_empty", inst_valid, 0);
        @(negedge clk);
        do_redirect(32'h200, 32'h200, 64);
        #3;
        chk("t6_fault_cleared", fetch_fault, 0);
        chk("t6_resume_addr", imem_req_addr, 32'h200);
        wait_outs(8, 100, "t6_resume_timeout");
`else
        do_redirect(32'h102, 32'h100, 64);
        #3;
        chk("t6_no_fault", fetch_fault, 0);
        chk("t6_aligned_addr", imem_req_addr, 32'h100);
        wait_outs(8, 100, "t6_stream_timeout");
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
